// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM state encoding and default bus/timeout sizes.
// Used by the APB initiator, the interconnect and APB slaves.
package apb_pkg;

  localparam int unsigned APB_ADDR_W_DEF  = 32;
  localparam int unsigned APB_DATA_W_DEF  = 32;
  localparam int unsigned APB_TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// APB initiator: one valid/ready request becomes one SETUP+ACCESS transfer; response 3 cycles after
// handshake plus wait states. Single outstanding transfer; req_ready_o low until the response is taken.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned APB_DATA_WIDTH = APB_DATA_W_DEF,
  parameter int unsigned APB_ADDR_WIDTH = APB_ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                        req_we_i,
  input  logic [APB_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [APB_DATA_WIDTH/8-1:0] req_strb_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
  output logic                        psel_o,
  output logic                        penable_o,
  output logic                        pwrite_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
  output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i
);

  localparam int unsigned STRB_W = APB_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter holds the number of ACCESS cycles already elapsed, so the last allowed cycle sees LIMIT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         strb_q, strb_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = SETUP;
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          strb_d  = req_we_i ? req_strb_i : '0;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // A pready in the final allowed cycle wins over the timeout.
        if (pready_i) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : prdata_i;
          err_d   = pslverr_i;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = addr_q;
  assign pwrite_o    = we_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = strb_q;

endmodule
